// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sequencer sharing one iterative divider between two requesters.
// Optional feature DIV_ARB_ZERO_BYPASS_EN answers zero divisors locally without kicking the divider.
module div_arbiter #(
  parameter int WAIT_LIMIT = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_0,
  input  logic        req_1,
  input  logic        rem_0,
  input  logic        rem_1,
  input  logic        uns_0,
  input  logic        uns_1,
  input  logic [31:0] a_0,
  input  logic [31:0] a_1,
  input  logic [31:0] b_0,
  input  logic [31:0] b_1,
  output logic        ack_0,
  output logic        ack_1,
  output logic        done_0,
  output logic        done_1,
  output logic [31:0] res_0,
  output logic [31:0] res_1,
  output logic        err_0,
  output logic        err_1,
  output logic        busy,
  output logic        div_kick,
  output logic        div_unsigned,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_ready,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder
);

  localparam int         DATA_W = 32;
  localparam logic [5:0] LIMIT  = 6'(WAIT_LIMIT);

`ifdef DIV_ARB_ZERO_BYPASS_EN
  typedef enum logic [2:0] {S_IDLE, S_KICK, S_SETTLE, S_WAIT, S_BYPASS} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_KICK, S_SETTLE, S_WAIT} state_t;
`endif

  state_t             state;
  logic [5:0]         wait_cnt;
  logic               last_grant;
  logic               owner;
  logic               rem_q;

  logic               any_req;
  logic               win_1;
  logic               grant;
  logic [DATA_W-1:0]  sel_a;
  logic [DATA_W-1:0]  sel_b;
  logic               sel_rem;
  logic               sel_uns;

  logic               fin_en;
  logic               fin_err;
  logic [DATA_W-1:0]  fin_res;

  // On a tie the requester that did not win last time takes the grant.
  always_comb begin
    any_req = req_0 | req_1;
    win_1   = (req_0 && req_1) ? ~last_grant : req_1;
    sel_a   = win_1 ? a_1 : a_0;
    sel_b   = win_1 ? b_1 : b_0;
    sel_rem = win_1 ? rem_1 : rem_0;
    sel_uns = win_1 ? uns_1 : uns_0;
`ifdef DIV_ARB_ZERO_BYPASS_EN
    grant   = any_req && (div_ready || (sel_b == '0));
`else
    grant   = any_req && div_ready;
`endif
  end

  always_comb begin
    fin_en  = 1'b0;
    fin_err = 1'b0;
    fin_res = '0;
    case (state)
      S_WAIT: begin
        if (div_ready) begin
          fin_en  = 1'b1;
          fin_res = rem_q ? div_remainder : div_quotient;
        end else if (wait_cnt == LIMIT) begin
          fin_en  = 1'b1;
          fin_err = 1'b1;
        end
      end
`ifdef DIV_ARB_ZERO_BYPASS_EN
      // x/0 yields all ones, x%0 yields the dividend.
      S_BYPASS: begin
        fin_en  = 1'b1;
        fin_res = rem_q ? div_a : '1;
      end
`endif
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      last_grant   <= 1'b1;
      owner        <= 1'b0;
      rem_q        <= 1'b0;
      ack_0        <= 1'b0;
      ack_1        <= 1'b0;
      done_0       <= 1'b0;
      done_1       <= 1'b0;
      res_0        <= '0;
      res_1        <= '0;
      err_0        <= 1'b0;
      err_1        <= 1'b0;
      div_kick     <= 1'b0;
      div_unsigned <= 1'b0;
      div_a        <= '0;
      div_b        <= '0;
    end else begin
      ack_0  <= 1'b0;
      ack_1  <= 1'b0;
      done_0 <= 1'b0;
      done_1 <= 1'b0;

      if (fin_en) begin
        if (owner) begin
          res_1  <= fin_res;
          err_1  <= fin_err;
          done_1 <= 1'b1;
        end else begin
          res_0  <= fin_res;
          err_0  <= fin_err;
          done_0 <= 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (grant) begin
            owner        <= win_1;
            last_grant   <= win_1;
            rem_q        <= sel_rem;
            div_a        <= sel_a;
            div_b        <= sel_b;
            div_unsigned <= sel_uns;
            ack_0        <= ~win_1;
            ack_1        <= win_1;
`ifdef DIV_ARB_ZERO_BYPASS_EN
            if (sel_b == '0) begin
              state <= S_BYPASS;
            end else begin
              div_kick <= 1'b1;
              state    <= S_KICK;
            end
`else
            div_kick <= 1'b1;
            state    <= S_KICK;
`endif
          end
        end
        S_KICK: begin
          div_kick <= 1'b0;
          state    <= S_SETTLE;
        end
        // The divider's ready may not have dropped yet, so it is not looked at here.
        S_SETTLE: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (fin_en) begin
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 6'd1;
          end
        end
`ifdef DIV_ARB_ZERO_BYPASS_EN
        S_BYPASS: state <= S_IDLE;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter with a behavioural divider and a round-robin/arith reference.
module tb_div_arbiter;

  localparam int WL = 63;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_0 = 1'b0, req_1 = 1'b0;
  logic        rem_0 = 1'b0, rem_1 = 1'b0;
  logic        uns_0 = 1'b0, uns_1 = 1'b0;
  logic [31:0] a_0 = '0, a_1 = '0, b_0 = '0, b_1 = '0;
  logic        ack_0, ack_1, done_0, done_1, err_0, err_1, busy;
  logic [31:0] res_0, res_1;
  logic        div_kick, div_unsigned;
  logic [31:0] div_a, div_b;
  logic        div_ready = 1'b1;
  logic [31:0] div_quotient = '0, div_remainder = '0;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   lat      = 2;
  logic stall    = 1'b0;
  int   cnt      = 0;
  int   last_w   = 1;

  div_arbiter #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .reset(reset),
    .req_0(req_0), .req_1(req_1), .rem_0(rem_0), .rem_1(rem_1),
    .uns_0(uns_0), .uns_1(uns_1), .a_0(a_0), .a_1(a_1), .b_0(b_0), .b_1(b_1),
    .ack_0(ack_0), .ack_1(ack_1), .done_0(done_0), .done_1(done_1),
    .res_0(res_0), .res_1(res_1), .err_0(err_0), .err_1(err_1), .busy(busy),
    .div_kick(div_kick), .div_unsigned(div_unsigned), .div_a(div_a), .div_b(div_b),
    .div_ready(div_ready), .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  always #5 clk = ~clk;

  // RISC-V style division semantics, including divide-by-zero and signed overflow.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic rem, input logic uns);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return rem ? a : 32'hFFFFFFFF;
    if (uns) return rem ? (a % b) : (a / b);
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return rem ? 32'd0 : a;
    return rem ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  // Iterative divider: ready drops the edge after a kick, rises lat edges later unless stalled.
  always @(posedge clk) begin
    if (div_kick) begin
      div_ready     <= 1'b0;
      cnt           <= lat;
      div_quotient  <= ref_div(div_a, div_b, 1'b0, div_unsigned);
      div_remainder <= ref_div(div_a, div_b, 1'b1, div_unsigned);
    end else if (!div_ready && !stall) begin
      if (cnt <= 1) div_ready <= 1'b1;
      else          cnt <= cnt - 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_b(input string name, input string item, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0b expected %0b", name, item, act, exp);
    end
  endtask

  task automatic check_w(input string name, input string item, input logic [31:0] act,
                         input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got 0x%08h expected 0x%08h", name, item, act, exp);
    end
  endtask

  task automatic check_i(input string name, input string item, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0d expected %0d", name, item, act, exp);
    end
  endtask

  task automatic set_req(input int who, input logic [31:0] a, input logic [31:0] b,
                         input logic rem, input logic uns);
    if (who == 1) begin
      req_1 = 1'b1; a_1 = a; b_1 = b; rem_1 = rem; uns_1 = uns;
    end else begin
      req_0 = 1'b1; a_0 = a; b_0 = b; rem_0 = rem; uns_0 = uns;
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check_b(name, "ack_0", ack_0, 1'b0);
    check_b(name, "ack_1", ack_1, 1'b0);
    check_b(name, "done_0", done_0, 1'b0);
    check_b(name, "done_1", done_1, 1'b0);
    check_b(name, "busy", busy, 1'b0);
    check_b(name, "div_kick", div_kick, 1'b0);
  endtask

  // Called in the cycle the ack is expected; counts cycles from the request edge to done.
  task automatic finish_op(input int who, input logic [31:0] exp_res, input logic exp_err,
                           input int exp_cyc, input logic exp_kick, input string name);
    int          cyc;
    logic        got;
    logic [31:0] held;
    cyc = 1;
    got = 1'b0;
    check_b(name, "ack", (who == 1) ? ack_1 : ack_0, 1'b1);
    check_b(name, "ack_other", (who == 1) ? ack_0 : ack_1, 1'b0);
    check_b(name, "busy", busy, 1'b1);
    check_b(name, "kick", div_kick, exp_kick);
    if (who == 1) req_1 = 1'b0; else req_0 = 1'b0;
    last_w = who;
    while (!got && cyc < 200) begin
      tick();
      cyc++;
      if (cyc == 2) check_b(name, "kick_pulse", div_kick, 1'b0);
      got = (who == 1) ? done_1 : done_0;
    end
    check_b(name, "done_seen", got, 1'b1);
    check_i(name, "latency", cyc, exp_cyc);
    held = (who == 1) ? res_1 : res_0;
    check_w(name, "res", held, exp_res);
    check_b(name, "err", (who == 1) ? err_1 : err_0, exp_err);
    check_b(name, "done_other", (who == 1) ? done_0 : done_1, 1'b0);
    tick();
    check_b(name, "done_pulse", (who == 1) ? done_1 : done_0, 1'b0);
    check_w(name, "res_hold", (who == 1) ? res_1 : res_0, held);
  endtask

  task automatic do_op(input int who, input logic [31:0] a, input logic [31:0] b,
                       input logic rem, input logic uns, input logic [31:0] exp_res,
                       input logic exp_err, input int exp_cyc, input logic exp_kick,
                       input string name);
    set_req(who, a, b, rem, uns);
    tick();
    finish_op(who, exp_res, exp_err, exp_cyc, exp_kick, name);
  endtask

  typedef struct {
    int          who;
    logic [31:0] a;
    logic [31:0] b;
    logic        rem;
    logic        uns;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t        vt[8];
  logic [31:0] ra[2], rb[2];
  logic        rr[2], ru[2];
  int          pat, w, n;
  logic        saw;

  initial begin
    vt[0] = '{0, 32'd100,        32'd7,        1'b0, 1'b0, 32'd14,        3};
    vt[1] = '{0, 32'd100,        32'd7,        1'b1, 1'b0, 32'd2,         1};
    vt[2] = '{1, 32'hFFFFFFF9,   32'd2,        1'b1, 1'b0, 32'hFFFFFFFF,  2};
    vt[3] = '{1, 32'hFFFFFFF9,   32'd2,        1'b0, 1'b0, 32'hFFFFFFFD,  5};
    vt[4] = '{0, 32'hFFFFFFF6,   32'd3,        1'b0, 1'b1, 32'h55555552,  4};
    vt[5] = '{0, 32'd7,          32'hFFFFFFFD, 1'b1, 1'b0, 32'd1,         2};
    vt[6] = '{1, 32'd7,          32'hFFFFFFFD, 1'b0, 1'b1, 32'd0,         1};
    vt[7] = '{1, 32'hFFFFFFFD,   32'd7,        1'b1, 1'b1, 32'd1,         6};

    // Reset state
    repeat (2) tick();
    check_idle_outputs("reset");
    check_w("reset", "res_0", res_0, 32'd0);
    check_w("reset", "res_1", res_1, 32'd0);
    check_b("reset", "err_0", err_0, 1'b0);
    check_b("reset", "err_1", err_1, 1'b0);
    check_w("reset", "div_a", div_a, 32'd0);
    check_w("reset", "div_b", div_b, 32'd0);
    check_b("reset", "div_unsigned", div_unsigned, 1'b0);
    reset = 1'b1;
    tick();
    check_idle_outputs("post_reset");

    // First tie after reset goes to 0, then 1 is acked at W+2; the next tie goes to 0 again.
    lat = 2;
    set_req(1, 32'hFFFFFFF6, 32'd3, 1'b0, 1'b1);
    do_op(0, 32'd10, 32'd3, 1'b0, 1'b1, 32'd3, 1'b0, 3 + lat, 1'b1, "tie_a");
    finish_op(1, 32'h55555552, 1'b0, 3 + lat, 1'b1, "tie_b");
    set_req(1, 32'd50, 32'd7, 1'b1, 1'b1);
    do_op(0, 32'd50, 32'd7, 1'b0, 1'b1, 32'd7, 1'b0, 3 + lat, 1'b1, "tie2_a");
    finish_op(1, 32'd1, 1'b0, 3 + lat, 1'b1, "tie2_b");

    // Single-requester vectors
    for (int i = 0; i < 8; i++) begin
      lat = vt[i].lat;
      do_op(vt[i].who, vt[i].a, vt[i].b, vt[i].rem, vt[i].uns, vt[i].exp, 1'b0,
            3 + vt[i].lat, 1'b1, $sformatf("vec%0d", i));
    end

    // Watchdog: divider never reports ready
    lat   = 3;
    stall = 1'b1;
    do_op(0, 32'd9, 32'd3, 1'b0, 1'b1, 32'd0, 1'b1, WL + 4, 1'b1, "watchdog");
    set_req(1, 32'd20, 32'd4, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_b("wd_hold", "ack_1", ack_1, 1'b0);
    end
    stall = 1'b0;
    n = 0;
    while (!ack_1 && n < 30) begin
      tick();
      n++;
    end
    finish_op(1, 32'd5, 1'b0, 3 + lat, 1'b1, "wd_next");

    // Zero divisor
    lat = 2;
`ifdef DIV_ARB_ZERO_BYPASS_EN
    do_op(0, 32'd5, 32'd0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 2, 1'b0, "zero_q");
    do_op(0, 32'd5, 32'd0, 1'b1, 1'b1, 32'd5, 1'b0, 2, 1'b0, "zero_r");
`else
    do_op(0, 32'd5, 32'd0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 3 + lat, 1'b1, "zero_q");
    do_op(0, 32'd5, 32'd0, 1'b1, 1'b1, 32'd5, 1'b0, 3 + lat, 1'b1, "zero_r");
`endif

    // Reset while the kick is high
    set_req(0, 32'd40, 32'd8, 1'b0, 1'b1);
    tick();
    check_b("rst_kick", "kick_before", div_kick, 1'b1);
    reset = 1'b0;
    #1;
    check_b("rst_kick", "kick", div_kick, 1'b0);
    check_b("rst_kick", "busy", busy, 1'b0);
    check_b("rst_kick", "ack_0", ack_0, 1'b0);
    req_0 = 1'b0;
    tick();
    reset  = 1'b1;
    last_w = 1;
    tick();

    // Reset during WAIT
    stall = 1'b1;
    lat   = 2;
    set_req(0, 32'd60, 32'd6, 1'b0, 1'b1);
    tick();
    req_0 = 1'b0;
    repeat (4) tick();
    check_b("rst_wait", "busy_before", busy, 1'b1);
    reset = 1'b0;
    #1;
    check_idle_outputs("rst_wait");
    check_w("rst_wait", "res_0", res_0, 32'd0);
    check_b("rst_wait", "err_0", err_0, 1'b0);
    check_w("rst_wait", "div_a", div_a, 32'd0);
    repeat (2) tick();
    reset  = 1'b1;
    stall  = 1'b0;
    last_w = 1;
    saw    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      saw = saw | done_0 | done_1;
    end
    check_b("rst_wait", "no_done", saw, 1'b0);
    do_op(1, 32'd60, 32'd6, 1'b0, 1'b1, 32'd10, 1'b0, 3 + lat, 1'b1, "post_rst");

    // Randomised traffic against the round-robin and arithmetic reference
    for (int k = 0; k < 40; k++) begin
      for (int j = 0; j < 2; j++) begin
        ra[j] = $urandom;
        rb[j] = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 40)) : $urandom;
        if (rb[j] == 32'd0) rb[j] = 32'd1;
        rr[j] = 1'($urandom_range(0, 1));
        ru[j] = 1'($urandom_range(0, 1));
      end
      pat = $urandom_range(1, 3);
      lat = $urandom_range(1, 6);
      w   = (pat == 3) ? 1 - last_w : ((pat == 2) ? 1 : 0);
      if ((pat & 1) != 0) set_req(0, ra[0], rb[0], rr[0], ru[0]);
      if ((pat & 2) != 0) set_req(1, ra[1], rb[1], rr[1], ru[1]);
      tick();
      finish_op(w, ref_div(ra[w], rb[w], rr[w], ru[w]), 1'b0, 3 + lat, 1'b1,
                $sformatf("rand%0d_w", k));
      if (pat == 3) begin
        finish_op(1 - w, ref_div(ra[1-w], rb[1-w], rr[1-w], ru[1-w]), 1'b0, 3 + lat, 1'b1,
                  $sformatf("rand%0d_l", k));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Round-robin arbiter and sequencer that shares one iterative `div` unit between two requesters, e.g. two executer lanes or an executer and a debug/CSR path. It serialises requests, launches the divider with a one-cycle kick, and waits for completion with a watchdog. It returns quotient or remainder to the winning requester with a one-cycle done pulse. It sits between the requesters and the `div` instance, driving that instance's kick, operand and flag inputs.

## Interface
- `WAIT_LIMIT`, default 63: maximum cycles spent in WAIT before abort; 6-bit counter, legal range 1..63.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low; clears all state immediately.
- `req_0` / `req_1` input 1: request from requester 0/1; hold high with operands stable until the matching ack.
- `rem_0` / `rem_1` input 1: 1 = return remainder, 0 = return quotient.
- `uns_0` / `uns_1` input 1: unsigned divide flag.
- `a_0` / `a_1` input 32: dividend.
- `b_0` / `b_1` input 32: divisor.
- `ack_0` / `ack_1` output 1: one-cycle pulse; request accepted and operands latched.
- `done_0` / `done_1` output 1: one-cycle pulse; `res_x` / `err_x` valid.
- `res_0` / `res_1` output 32: result; held until the next `done_x`.
- `err_0` / `err_1` output 1: watchdog abort; valid with `done_x`.
- `busy` output 1: high in any state other than IDLE.
- `div_kick` output 1: kick to `div`.
- `div_unsigned` output 1: to `div`.
- `div_a`, `div_b` output 32: dividend and divisor to `div`.
- `div_ready` input 1: from `div`.
- `div_quotient`, `div_remainder` input 32: from `div`.

## Operation
- States:
  - IDLE: grant a request when at least one `req_x`=1 **and** `div_ready`=1. Latch `a`, `b`, `uns`, `rem` and the owner index. Set `ack_owner`←1, `div_kick`←1, go to KICK.
  - KICK: `div_kick`←0, `ack`←0, go to SETTLE.
  - SETTLE: ignore `div_ready`, clear the watchdog counter, go to WAIT.
  - WAIT:
    - If `div_ready`=1: set `res_owner`←(`rem` ? `div_remainder` : `div_quotient`), `err_owner`←0, `done_owner`←1, go to IDLE.
    - Else if the counter equals `WAIT_LIMIT`: set `res_owner`←0, `err_owner`←1, `done_owner`←1, go to IDLE.
    - Else increment the counter.
  - BYPASS: exists only with `DIV_ARB_ZERO_BYPASS_EN`; see Configuration.
- Arbitration:
  - If only one requester is asserting, that requester wins.
  - If both assert, the requester not granted last wins.
  - `last_grant` updates on every grant and resets to 1, so requester 0 wins the first tie.
- Requests are sampled only in IDLE. A requester must drop `req_x` by the cycle after its ack unless it is issuing a new operation.
- `done_x` and `ack_x` are pulses that clear after one cycle. `res_x` and `err_x` hold their values.
- Operands driven on `div_a` / `div_b` / `div_unsigned` stay stable from the grant until the return to IDLE.

## Timing
- Reset values:
  - All outputs 0, including `res_x` = 0x00000000.
  - State IDLE, counter 0, `last_grant` = 1.
- Grant: request seen in IDLE at cycle T gives `ack` and `div_kick` high at T+1, SETTLE at T+2, WAIT from T+3.
- Completion: `div_ready` seen in WAIT at cycle W gives `done` at W+1. IDLE is also at W+1, so the next grant can be acked at W+2.
- Back-to-back: both requesters held high are served alternately 0,1,0,1 with no extra idle cycle beyond the one IDLE cycle.
- Watchdog: `done` with `err` arrives `WAIT_LIMIT`+1 cycles after entering WAIT. The divider may still be busy; IDLE then withholds grants until `div_ready`=1.
- Reset asserted mid-operation: everything returns to reset values asynchronously, `div_kick` drops immediately, and no done is issued for the lost operation.
- `req_x` falling before its ack (illegal): ignored if it occurs outside IDLE. If it occurs in IDLE, there is no grant.

## Configuration
- `DIV_ARB_ZERO_BYPASS_EN` defined:
  - In IDLE, a granted request with `b`=0 does not kick the divider (`div_kick` stays 0).
  - The arbiter acks at T+1 and goes to BYPASS.
  - BYPASS sets `done` at T+2 with `res` = 0xFFFFFFFF when quotient is requested, or `a` when remainder is requested. `err`=0.
  - The bypass path does not require `div_ready`.
- Not defined: there is no BYPASS state, and a zero divisor goes through the normal kick/WAIT path.

## Test plan
- Single op: req_0, a=100, b=7, rem=0 → ack_0 at T+1, one div_kick pulse, done_0 with res_0=14 one cycle after div_ready; then rem=1 → res_0=2.
- Contention: req_0 and req_1 asserted in the same cycle after reset (unsigned, a_0=10,b_0=3; a_1=0xFFFFFFF6,b_1=3) → order 0 then 1; res_0=3, res_1=0x55555552; the next tie is granted to 0.
- Signed: uns_1=0, a_1=−7, b_1=2, rem=1 → res_1=0xFFFFFFFF (−1), err_1=0.
- Watchdog: divider model holds div_ready=0 forever → done_0 with err_0=1, res_0=0 after `WAIT_LIMIT`+1 cycles in WAIT; a new req_1 is not acked until div_ready is forced high.
- Zero divisor, macro on: a_0=5, b_0=0 → no div_kick, done_0 at T+2 with res=0xFFFFFFFF (quotient) or 5 (remainder); macro off → div_kick issued.
- Reset mid-WAIT: assert reset → div_kick, busy, ack and done go to 0 at once; after release no done_x appears and the next request is served normally.
